// File: rtl/gpu_common_pkg.sv
// Shared GPU datapath helpers: default pipe geometry and occupancy-counter width.
package gpu_common_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // A counter covering 0..depth needs clog2(depth+1) bits, never fewer than one.
    function automatic int occ_width(input int depth);
        int w;
        w = clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flop_stage.sv
// One pipeline stage: a valid bit plus a data word that loads only when the source is valid.
module flop_stage
    import gpu_common_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_ld,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Flush clears the valid bit only; data is left alone so bubbles never toggle the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_ld) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/flop_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline with flush and occupancy count.
// Define FLOP_PIPE_BUBBLE_COLLAPSE_EN to let empty stages fill while the output is stalled.
module flop_pipe
    import gpu_common_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [occ_width(DEPTH)-1:0]   occ
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_ld;
    logic [DEPTH-1:0] w_srcValid;
    logic [WIDTH-1:0] w_data    [DEPTH];
    logic [WIDTH-1:0] w_srcData [DEPTH];

`ifdef FLOP_PIPE_BUBBLE_COLLAPSE_EN
    // A stage may load whenever some stage at or beyond it has room, so the chain
    // reduces to "a hole exists downstream"; walking from the output avoids a comb loop.
    always_comb begin
        logic hole;
        w_ld = '0;
        hole = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hole    = hole || !w_valid[k];
            w_ld[k] = hole;
        end
    end
`else
    always_comb begin
        w_ld = {DEPTH{!w_valid[DEPTH-1] || out_ready}};
    end
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_srcValid[k] = in_valid;
            assign w_srcData[k]  = in_data;
        end else begin : g_body
            assign w_srcValid[k] = w_valid[k-1];
            assign w_srcData[k]  = w_data[k-1];
        end

        flop_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush),
            .i_ld    (w_ld[k]),
            .i_valid (w_srcValid[k]),
            .i_data  (w_srcData[k]),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k])
        );
    end

    assign in_ready  = w_ld[0] && !flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(w_valid[k]);
        end
    end

endmodule

// File: tb/tb_flop_pipe.sv
// Self-checking bench for flop_pipe (DEPTH=3, RESET_VAL=DEAD_BEEF) against a slot/queue model.
module tb_flop_pipe;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 3;
    localparam logic [31:0] RV    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  occ;

    int errors = 0;
    int checks = 0;

    // Model: slot array of (valid, data) plus a FIFO of accepted-but-not-emitted words.
    bit          mv [DEPTH];
    logic [31:0] md [DEPTH];
    logic [31:0] sb [$];

    flop_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic bit expInReady();
        bit room;
        room = out_ready || !mv[DEPTH-1];
`ifdef FLOP_PIPE_BUBBLE_COLLAPSE_EN
        for (int k = 0; k < DEPTH; k++) begin
            if (!mv[k]) room = 1'b1;
        end
`endif
        return room && !flush;
    endfunction

    function automatic int expOcc();
        int n;
        n = 0;
        for (int k = 0; k < DEPTH; k++) n += int'(mv[k]);
        return n;
    endfunction

    // Advance the model on each edge from the inputs presented before it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mv[k] = 1'b0;
                md[k] = RV;
            end
            sb.delete();
        end else begin : step
            bit inFire;
            bit outFire;
            inFire  = in_valid && expInReady();
            outFire = mv[DEPTH-1] && out_ready;
            if (outFire && sb.size() > 0) void'(sb.pop_front());
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) mv[k] = 1'b0;
                sb.delete();
            end else begin
                if (inFire) sb.push_back(in_data);
`ifdef FLOP_PIPE_BUBBLE_COLLAPSE_EN
                if (outFire) mv[DEPTH-1] = 1'b0;
                for (int k = DEPTH - 2; k >= 0; k--) begin
                    if (mv[k] && !mv[k+1]) begin
                        mv[k+1] = 1'b1;
                        md[k+1] = md[k];
                        mv[k]   = 1'b0;
                    end
                end
                if (!mv[0]) begin
                    mv[0] = inFire;
                    if (inFire) md[0] = in_data;
                end
`else
                if (out_ready || !mv[DEPTH-1]) begin
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        if (mv[k-1]) md[k] = md[k-1];
                        mv[k] = mv[k-1];
                    end
                    mv[0] = in_valid;
                    if (in_valid) md[0] = in_data;
                end
`endif
            end
        end
    end

    // Every cycle: DUT against slot model, and emitted words against the accept order.
    always @(negedge clk) begin
        checkOutput("out_valid", 32'(out_valid), 32'(mv[DEPTH-1]));
        checkOutput("occ", 32'(occ), 32'(expOcc()));
        checkOutput("in_ready", 32'(in_ready), 32'(expInReady()));
        checkOutput("out_data", out_data, md[DEPTH-1]);
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_underflow: got word %h expected none at %0t", out_data, $time);
            end else begin
                checkOutput("sb_order", out_data, sb[0]);
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        bit pending;
        pending = 1'b0;

        // Reset and idle
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_occ", 32'(occ), 32'd0);
        checkOutput("rst_out_data", out_data, RV);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("idle_out_data", out_data, RV);
        checkOutput("idle_occ", 32'(occ), 32'd0);

        // Streaming: words 1..4 emerge after the 3rd..6th edges
        applyStimulus(1, 1, 1, 0);
        checkOutput("stream_occ1", 32'(occ), 32'd1);
        applyStimulus(1, 2, 1, 0);
        checkOutput("stream_valid2", 32'(out_valid), 32'd0);
        applyStimulus(1, 3, 1, 0);
        checkOutput("stream_out1", out_data, 32'd1);
        checkOutput("stream_occ3", 32'(occ), 32'd3);
        applyStimulus(1, 4, 1, 0);
        checkOutput("stream_out2", out_data, 32'd2);
        applyStimulus(0, 0, 1, 0);
        checkOutput("stream_out3", out_data, 32'd3);
        checkOutput("stream_occ_drain", 32'(occ), 32'd2);
        applyStimulus(0, 0, 1, 0);
        checkOutput("stream_out4", out_data, 32'd4);
        applyStimulus(0, 0, 1, 0);
        checkOutput("stream_empty", 32'(out_valid), 32'd0);

        // Backpressure: fill, stall five cycles, then drain in order
        applyStimulus(1, 10, 0, 0);
        applyStimulus(1, 11, 0, 0);
        applyStimulus(1, 12, 0, 0);
        checkOutput("bp_full_occ", 32'(occ), 32'd3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 13, 0, 0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_data", out_data, 32'd10);
        end
        applyStimulus(1, 13, 1, 0);
        checkOutput("bp_rel_11", out_data, 32'd11);
        applyStimulus(0, 0, 1, 0);
        checkOutput("bp_rel_12", out_data, 32'd12);
        applyStimulus(0, 0, 1, 0);
        checkOutput("bp_rel_13", out_data, 32'd13);
        applyStimulus(0, 0, 1, 0);
        checkOutput("bp_drained", 32'(occ), 32'd0);

        // Bubble collapse: one word parked in the last stage, output stalled
        applyStimulus(1, 20, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("bub_occ1", 32'(occ), 32'd1);
        applyStimulus(1, 21, 0, 0);
`ifdef FLOP_PIPE_BUBBLE_COLLAPSE_EN
        checkOutput("bub_occ_a", 32'(occ), 32'd2);
        checkOutput("bub_ready_a", 32'(in_ready), 32'd1);
        applyStimulus(1, 22, 0, 0);
        checkOutput("bub_occ_b", 32'(occ), 32'd3);
`else
        checkOutput("bub_occ_a", 32'(occ), 32'd1);
        checkOutput("bub_ready_a", 32'(in_ready), 32'd0);
        applyStimulus(1, 21, 0, 0);
        checkOutput("bub_occ_b", 32'(occ), 32'd1);
`endif
        checkOutput("bub_ready_b", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);

        // Flush collision on a full pipe
        applyStimulus(1, 30, 1, 0);
        applyStimulus(1, 31, 1, 0);
        applyStimulus(1, 32, 1, 0);
        checkOutput("fl_full", 32'(occ), 32'd3);
        in_valid  = 1'b1;
        in_data   = 32'd33;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        checkOutput("fl_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_occ", 32'(occ), 32'd0);
        checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);

        // Async reset mid-stream with two words in flight
        applyStimulus(1, 40, 0, 0);
        applyStimulus(1, 41, 0, 0);
        checkOutput("ar_occ2", 32'(occ), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
        checkOutput("ar_occ0", 32'(occ), 32'd0);
        checkOutput("ar_out_data", out_data, RV);
        in_valid  = 1'b1;
        in_data   = 32'd42;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ar_first_accept", 32'(occ), 32'd1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("ar_out42", out_data, 32'd42);
        applyStimulus(0, 0, 1, 0);

        // Randomized traffic; a refused word is held until accepted
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            pending = in_valid && !in_ready;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flop_pipe.md
Name: flop_pipe

Overview:
- Parametrised successor to the single-bit flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking.
- Adds valid/ready backpressure, synchronous flush, a programmable reset value and an occupancy count.
- Used in GPU datapaths for retiming long routes and balancing pipeline latency wherever the consumer can stall.

Parameters:
- WIDTH, 32, data bits per stage (>=1)
- DEPTH, 2, number of register stages (>=1)
- RESET_VAL, {WIDTH{1'b0}}, data value every stage takes on reset

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- flush  input  1  synchronous flush; invalidates all stages
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipe accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  last-stage data
- occ  output  $clog2(DEPTH+1)  count of valid stages

Behaviour:
- Stage state: v[k] and data[k], k = 0..DEPTH-1. Stage 0 is the input side; out_valid = v[DEPTH-1], out_data = data[DEPTH-1].
- Reset (rst==0, asynchronous): all v[k] = 0, all data[k] = RESET_VAL. Hence out_valid = 0, occ = 0, out_data = RESET_VAL, in_ready = 1 (while flush = 0).
- Transfers: a transfer occurs on cycle edges where valid && ready. in_valid must be held until in_ready; out_ready may toggle freely.
- Default mode (lockstep advance):
  - adv = !v[DEPTH-1] || out_ready.
  - in_ready = adv && !flush.
  - When adv: v[0] <= in_valid; v[k] <= v[k-1].
  - A data register loads only when its source is valid; otherwise it holds its previous value (no toggling on bubbles).
  - When !adv: all stages hold.
- Latency: exactly DEPTH cycles from input transfer to out_valid when never stalled. Throughput is 1 per cycle.
- Flush (sampled at posedge):
  - All v[k] <= 0; data unchanged.
  - in_ready = 0 that cycle, so no input is accepted.
  - Overrides adv and any simultaneous input or output handshake. An out_valid/out_ready pair asserted in the flush cycle still counts as consumed.
- occ = popcount(v), combinational from the registered valids. Range is 0..DEPTH; full occupancy = DEPTH.
- Full pipe with out_ready = 0: in_ready = 0 and all contents hold indefinitely.
- Full pipe with out_ready = 1: simultaneous accept and emit; occ stays DEPTH.
- Reset asserted mid-transfer: all in-flight data is dropped and nothing is emitted after release. First accept is possible on the first posedge after release.
- Ordering: data order is strictly preserved. No duplication or loss except by flush or reset.

Optional Feature:
- Macro: FLOP_PIPE_BUBBLE_COLLAPSE_EN.
- Defined:
  - Per-stage load enables: ld[DEPTH-1] = !v[DEPTH-1] || out_ready; ld[k] = !v[k] || ld[k+1].
  - in_ready = ld[0] && !flush.
  - Stage k updates only when ld[k]; invalid stages fill even while the output is stalled.
  - A stalled pipe therefore compacts and accepts up to DEPTH entries. Minimum latency is still DEPTH.
- Undefined: lockstep advance as above. With the output stalled, occupancy never increases; bubbles are not squeezed out.

Decomposition:
- Shared package/header gpu_common_pkg:
  - occupancy-width function clog2 (DEPTH+1 handling)
  - default WIDTH/DEPTH localparams
- Natural sub-module: flop_stage. It holds one v/data pair with load-enable, valid-in, flush, async active-low reset and RESET_VAL; the top instantiates DEPTH of them in a generate loop.

Test Plan:
- Reset/idle: rst=0 with RESET_VAL=32'hDEAD_BEEF, then release with no input -> out_valid=0, occ=0, out_data=32'hDEAD_BEEF, in_ready=1.
- Latency/streaming: DEPTH=3, out_ready=1, inputs 1,2,3,4 on consecutive cycles -> out 1..4 appear on cycles 3..6 in order; occ peaks at 3.
- Backpressure: fill a DEPTH=3 pipe, hold out_ready=0 for 5 cycles -> in_ready=0, occ=3, out_data stable; release -> data drains in order with no loss.
- Bubble collapse: only v[2] valid, out_ready=0, in_valid=1 for 2 cycles -> with FLOP_PIPE_BUBBLE_COLLAPSE_EN occ reaches 3 and in_ready drops only when full; without it, in_ready=0 and occ stays 1.
- Flush collision: full pipe, flush=1 together with in_valid=1 and out_ready=1 -> next cycle occ=0, out_valid=0, the input is not accepted, and the output word counts as consumed.
- Async reset mid-stream: drop rst between clock edges while occ=2 -> out_valid falls immediately and no stale word appears after release.
